// File: rtl/axi_pkg.sv
// Shared AXI definitions for the asi_w write responder: default bus widths,
// burst and response codes, and the packed AW request / B response records
// that travel through the internal FIFOs.
package axi_pkg;

    localparam int AXI_DW_DEF     = 128;
    localparam int AXI_AW_DEF     = 32;
    localparam int AXI_IW_DEF     = 8;
    localparam int AXI_LW_DEF     = 8;
    localparam int AXI_SW_DEF     = 3;
    localparam int AXI_BURSTW_DEF = 2;
    localparam int AXI_BRESPW_DEF = 2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef struct packed {
        logic [AXI_IW_DEF-1:0]     id;
        logic [AXI_AW_DEF-1:0]     addr;
        logic [AXI_LW_DEF-1:0]     len;
        logic [AXI_SW_DEF-1:0]     size;
        logic [AXI_BURSTW_DEF-1:0] burst;
    } aw_req_t;

    typedef struct packed {
        logic [AXI_IW_DEF-1:0]     id;
        logic [AXI_BRESPW_DEF-1:0] resp;
    } b_rsp_t;

endpackage

// File: rtl/asi_w_if.sv
// AXI4 write-channel bundle (AW, W, B) between an AXI write master and the
// asi_w responder. The master modport drives requests, the slave modport
// drives the ready/response side.
interface asi_w_if
    import axi_pkg::*;
#(
    parameter int AXI_DW     = AXI_DW_DEF,
    parameter int AXI_AW     = AXI_AW_DEF,
    parameter int AXI_IW     = AXI_IW_DEF,
    parameter int AXI_LW     = AXI_LW_DEF,
    parameter int AXI_SW     = AXI_SW_DEF,
    parameter int AXI_BURSTW = AXI_BURSTW_DEF,
    parameter int AXI_BRESPW = AXI_BRESPW_DEF
);
    localparam int AXI_WSTRBW = AXI_DW / 8;

    logic [AXI_IW-1:0]     AWID;
    logic [AXI_AW-1:0]     AWADDR;
    logic [AXI_LW-1:0]     AWLEN;
    logic [AXI_SW-1:0]     AWSIZE;
    logic [AXI_BURSTW-1:0] AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [AXI_DW-1:0]     WDATA;
    logic [AXI_WSTRBW-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [AXI_IW-1:0]     BID;
    logic [AXI_BRESPW-1:0] BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/asi_fifo.sv
// Small synchronous FIFO used for the AW request queue and the B response
// queue. A push is taken while full when a pop happens in the same cycle,
// so push and pop together are legal at any occupancy. DEPTH must be a
// power of two (>= 2).
module asi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/asi_w.sv
// AXI4 write responder: queues AW requests, accepts W beats for one burst at
// a time, generates per-beat byte addresses for a simple user write port and
// returns B responses in AW order.
// Build option: define ASI_WRAP_EN to generate wrapping addresses for WRAP
// bursts (OKAY response); without it WRAP bursts are addressed as INCR, the
// data is still written and the response is SLVERR.
module asi_w
    import axi_pkg::*;
#(
    parameter int AXI_DW     = AXI_DW_DEF,
    parameter int AXI_AW     = AXI_AW_DEF,
    parameter int AXI_IW     = AXI_IW_DEF,
    parameter int AXI_LW     = AXI_LW_DEF,
    parameter int AXI_SW     = AXI_SW_DEF,
    parameter int AXI_BURSTW = AXI_BURSTW_DEF,
    parameter int AXI_BRESPW = AXI_BRESPW_DEF,
    parameter int ASI_AD     = 4,
    parameter int ASI_BD     = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    asi_w_if.slave                 axi,
    output logic                   usr_wen,
    output logic [AXI_AW-1:0]      usr_waddr,
    output logic [AXI_DW-1:0]      usr_wdata,
    output logic [AXI_DW/8-1:0]    usr_wstrb,
    input  logic                   usr_wready
);
    localparam int AXI_WSTRBW = AXI_DW / 8;
    localparam int L          = $clog2(AXI_WSTRBW);
    localparam logic [AXI_SW-1:0] MAX_SIZE = AXI_SW'(L);
    localparam logic [AXI_AW-1:0] ADDR_ONE = {{(AXI_AW-1){1'b0}}, 1'b1};

`ifdef ASI_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    // Address of the beat after the current one, modulo 2^AXI_AW.
    function automatic logic [AXI_AW-1:0] next_addr(
        input logic [AXI_AW-1:0]     addr,
        input logic [AXI_LW-1:0]     len,
        input logic [AXI_SW-1:0]     size,
        input logic [AXI_BURSTW-1:0] burst
    );
        logic [AXI_AW-1:0] step;
        logic [AXI_AW-1:0] aligned;
        logic [AXI_AW-1:0] incr;
        logic [AXI_AW-1:0] bound;
        logic [AXI_AW-1:0] mask;
        logic [AXI_AW-1:0] wrapped;
        step    = ADDR_ONE << size;
        aligned = addr & ~(step - ADDR_ONE);
        incr    = aligned + step;
        bound   = (AXI_AW'(len) + ADDR_ONE) << size;
        mask    = bound - ADDR_ONE;
        wrapped = (addr & ~mask) | (incr & mask);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = WRAP_EN ? wrapped : incr;
            default:     next_addr = incr;
        endcase
    endfunction

    // Burst types that complete normally but must report SLVERR.
    function automatic logic burst_err(input logic [AXI_BURSTW-1:0] burst);
        case (burst)
            BURST_RSVD: burst_err = 1'b1;
            BURST_WRAP: burst_err = ~WRAP_EN;
            default:    burst_err = 1'b0;
        endcase
    endfunction

    aw_req_t aw_din, aw_dout;
    logic    aw_push, aw_pop, aw_full, aw_empty;
    b_rsp_t  b_din, b_dout;
    logic    b_push, b_pop, b_full, b_empty;

    state_e                  state_q, state_d;
    logic                    rst_done;
    logic [AXI_AW-1:0]       addr_q, addr_d;
    logic [AXI_LW-1:0]       len_q, len_d;
    logic [AXI_SW-1:0]       size_q, size_d;
    logic [AXI_BURSTW-1:0]   burst_q, burst_d;
    logic [AXI_IW-1:0]       id_q, id_d;
    logic [AXI_LW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                    inh_q, inh_d;
    logic                    err_q, err_d;
    logic                    wready;
    logic                    beat;
    logic                    last_beat;
    logic                    err_now;
    logic [AXI_BRESPW-1:0]   resp_now;

    asi_fifo #(.WIDTH($bits(aw_req_t)), .DEPTH(ASI_AD)) u_aw_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (aw_push),
        .din   (aw_din),
        .pop   (aw_pop),
        .dout  (aw_dout),
        .full  (aw_full),
        .empty (aw_empty)
    );

    asi_fifo #(.WIDTH($bits(b_rsp_t)), .DEPTH(ASI_BD)) u_b_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (b_push),
        .din   (b_din),
        .pop   (b_pop),
        .dout  (b_dout),
        .full  (b_full),
        .empty (b_empty)
    );

    // AW channel: accept whenever the request queue has room (never in reset).
    assign axi.AWREADY = rst_done & ~aw_full;
    assign aw_push     = axi.AWVALID & axi.AWREADY;
    assign aw_din      = '{id: axi.AWID, addr: axi.AWADDR, len: axi.AWLEN,
                           size: axi.AWSIZE, burst: axi.AWBURST};

    // B channel: head of the response queue, zeros when nothing is pending.
    assign axi.BVALID = ~b_empty;
    assign axi.BID    = b_empty ? '0 : b_dout.id;
    assign axi.BRESP  = b_empty ? '0 : b_dout.resp;
    assign b_pop      = axi.BVALID & axi.BREADY;

    // W channel and user write port follow the burst in progress.
    assign axi.WREADY = wready;
    assign usr_wen    = beat & ~inh_q;
    assign usr_waddr  = (state_q == ST_DATA) ? addr_q    : '0;
    assign usr_wdata  = (state_q == ST_DATA) ? axi.WDATA : '0;
    assign usr_wstrb  = (state_q == ST_DATA) ? axi.WSTRB : '0;

    // AWREADY is held low until the first clock after reset release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    // Burst FSM state and per-burst control flags.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            inh_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            inh_q      <= inh_d;
            err_q      <= err_d;
        end
    end

    // Burst descriptor; loaded from the AW queue before any beat uses it.
    always_ff @(posedge ACLK) begin
        addr_q  <= addr_d;
        len_q   <= len_d;
        size_q  <= size_d;
        burst_q <= burst_d;
        id_q    <= id_d;
    end

    // Next-state, burst load, beat counting and response generation.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        id_d       = id_q;
        beat_cnt_d = beat_cnt_q;
        inh_d      = inh_q;
        err_d      = err_q;
        aw_pop     = 1'b0;
        b_push     = 1'b0;
        wready     = 1'b0;
        beat       = 1'b0;
        last_beat  = (beat_cnt_q == len_q);
        err_now    = err_q;
        resp_now   = RESP_OKAY;
        case (state_q)
            ST_IDLE: begin
                // A burst is only started when its response is guaranteed a slot.
                if (!aw_empty && !b_full) begin
                    aw_pop     = 1'b1;
                    addr_d     = aw_dout.addr;
                    len_d      = aw_dout.len;
                    size_d     = aw_dout.size;
                    burst_d    = aw_dout.burst;
                    id_d       = aw_dout.id;
                    beat_cnt_d = '0;
                    inh_d      = (aw_dout.size > MAX_SIZE);
                    err_d      = (aw_dout.size > MAX_SIZE) | burst_err(aw_dout.burst);
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                wready = usr_wready;
                beat   = axi.WVALID & usr_wready;
                if (beat) begin
                    // The beat counter decides the burst end; WLAST only flags errors.
                    err_now = err_q | (axi.WLAST != last_beat);
                    err_d   = err_now;
                    if (last_beat) begin
                        resp_now = err_now ? RESP_SLVERR : RESP_OKAY;
                        b_push   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + AXI_LW'(1);
                        addr_d     = next_addr(addr_q, len_q, size_q, burst_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        b_din = '{id: id_q, resp: resp_now};
    end

endmodule
